// File: rtl/score_counter_bcd.sv
// Up/down score counter with synchronised button edge detection, saturate/wrap limits
// and registered two-digit BCD outputs that always match the binary count.
module score_counter_bcd #(
    parameter int BW          = 7,
    parameter int MAX_VAL     = 99,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          up_i,
    input  logic          down_i,
    input  logic          clr_i,
    input  logic          wrap_i,
    output logic [BW-1:0] count_o,
    output logic [3:0]    tens_o,
    output logic [3:0]    ones_o,
    output logic          at_max_o,
    output logic          at_min_o,
    output logic          limit_o
);

    localparam logic [BW-1:0] MAX_C    = BW'(MAX_VAL);
    localparam logic [3:0]    MAX_TENS = 4'(MAX_VAL / 10);
    localparam logic [3:0]    MAX_ONES = 4'(MAX_VAL % 10);
    localparam int            WARM     = SYNC_STAGES + 1;
    localparam int            WW       = $clog2(WARM + 1);
    localparam logic [WW-1:0] WARM_C   = WW'(WARM);

    logic [SYNC_STAGES-1:0] r_up_sync;
    logic [SYNC_STAGES-1:0] r_dn_sync;
    logic                   r_up_prev;
    logic                   r_dn_prev;
    logic [WW-1:0]          r_warm;
    logic [BW-1:0]          r_count;
    logic [3:0]             r_tens;
    logic [3:0]             r_ones;
    logic                   r_limit;

    logic                   w_ready;
    logic                   w_step_up;
    logic                   w_step_dn;
    logic [BW-1:0]          w_count_nxt;
    logic [3:0]             w_tens_nxt;
    logic [3:0]             w_ones_nxt;
    logic                   w_limit_nxt;

    // Synchronisers and edge-detect history run unconditionally, including during clear.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_up_sync <= '0;
            r_dn_sync <= '0;
            r_up_prev <= 1'b0;
            r_dn_prev <= 1'b0;
        end else begin
            r_up_sync <= {r_up_sync[SYNC_STAGES-2:0], up_i};
            r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], down_i};
            r_up_prev <= r_up_sync[SYNC_STAGES-1];
            r_dn_prev <= r_dn_sync[SYNC_STAGES-1];
        end
    end

    // After reset the pipeline refills from zero; a button held through reset would look like
    // a fresh edge, so steps stay masked until the prev-flops have caught up with the input.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_warm <= '0;
        end else if (r_warm != WARM_C) begin
            r_warm <= r_warm + WW'(1);
        end
    end

    assign w_ready   = (r_warm == WARM_C);
    assign w_step_up = w_ready & r_up_sync[SYNC_STAGES-1] & ~r_up_prev;
    assign w_step_dn = w_ready & r_dn_sync[SYNC_STAGES-1] & ~r_dn_prev;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_count_nxt = r_count;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_limit_nxt = 1'b0;
        if (clr_i) begin
            w_count_nxt = '0;
            w_tens_nxt  = 4'd0;
            w_ones_nxt  = 4'd0;
        end else if (w_step_up && w_step_dn) begin
            w_limit_nxt = 1'b0;
        end else if (w_step_up) begin
            if (r_count == MAX_C) begin
                w_limit_nxt = 1'b1;
                if (wrap_i) begin
                    w_count_nxt = '0;
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                end
            end else begin
                w_count_nxt = r_count + BW'(1);
                if (r_ones == 4'd9) begin
                    w_ones_nxt = 4'd0;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt = r_ones + 4'd1;
                end
            end
        end else if (w_step_dn) begin
            if (r_count == '0) begin
                w_limit_nxt = 1'b1;
                if (wrap_i) begin
                    w_count_nxt = MAX_C;
                    w_tens_nxt  = MAX_TENS;
                    w_ones_nxt  = MAX_ONES;
                end
            end else begin
                w_count_nxt = r_count - BW'(1);
                if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_limit <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_limit <= w_limit_nxt;
        end
    end

    assign count_o  = r_count;
    assign tens_o   = r_tens;
    assign ones_o   = r_ones;
    assign limit_o  = r_limit;
    assign at_max_o = (r_count == MAX_C);
    assign at_min_o = (r_count == '0);

endmodule
